// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access-size codes and the alignment rule.
// Imported by dmem_arbiter and dmem_arb_pick.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        ERR_RSP  = 2'd3
    } state_e;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    // Size code 2'b11 has no meaning and is always rejected.
    function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] mask);
        logic ok;
        case (mask)
            MASK_B:  ok = 1'b1;
            MASK_H:  ok = ~addr_lo[0];
            MASK_W:  ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way grant select: a lone valid port wins; ties go round-robin (DMEM_ARB_RR_EN) or to port 0.
// Latency: purely combinational. Backpressure: none, the caller decides when the grant is used.
module dmem_arb_pick (
    input  logic [1:0] req_valid,
    input  logic       rr_last,
    output logic       gnt_vld,
    output logic       gnt_idx
);

`ifndef DMEM_ARB_RR_EN
    logic unused_rr_last;
    assign unused_rr_last = rr_last;
`endif

    always_comb begin
        gnt_vld = |req_valid;
        gnt_idx = 1'b0;
        if (req_valid == 2'b10) begin
            gnt_idx = 1'b1;
        end else if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            gnt_idx = ~rr_last;
`else
            gnt_idx = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the LSU (port 0) and a secondary master (port 1); tie policy via DMEM_ARB_RR_EN.
// Latency: accept at cycle 0, memory request from cycle 1, response >= cycle 2 (error response at cycle 1).
// Backpressure: one transaction outstanding; losers hold until granted in IDLE, mem_req held until mem_req_ready.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [1:0]            req_wen,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [3:0]            req_mask,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [1:0]            mem_mask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata
);
    import dmem_arb_pkg::*;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                rr_last_q, rr_last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          mask_q, mask_d;

    logic                gnt_vld;
    logic                gnt_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_wen;
    logic [DATA_W-1:0]   sel_wdata;
    logic [1:0]          sel_mask;

    logic [1:0]          req_ready_c;
    logic [1:0]          rsp_valid_c;
    logic [DATA_W-1:0]   rsp_rdata_c;
    logic                rsp_err_c;
    logic                mem_req_valid_c;

    dmem_arb_pick u_pick (
        .req_valid (req_valid),
        .rr_last   (rr_last_q),
        .gnt_vld   (gnt_vld),
        .gnt_idx   (gnt_idx)
    );

    assign sel_addr  = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_wdata = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign sel_wen   = gnt_idx ? req_wen[1]                   : req_wen[0];
    assign sel_mask  = gnt_idx ? req_mask[3:2]                : req_mask[1:0];

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_last_d       = rr_last_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        mask_d          = mask_q;
        req_ready_c     = 2'b00;
        rsp_valid_c     = 2'b00;
        rsp_rdata_c     = '0;
        rsp_err_c       = 1'b0;
        mem_req_valid_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    req_ready_c[gnt_idx] = 1'b1;
                    owner_d   = gnt_idx;
                    rr_last_d = gnt_idx;
                    addr_d    = sel_addr;
                    wen_d     = sel_wen;
                    wdata_d   = sel_wdata;
                    mask_d    = sel_mask;
                    state_d   = is_aligned(sel_addr[1:0], sel_mask) ? ISSUE : ERR_RSP;
                end
            end
            ISSUE: begin
                // Any mem_rsp_valid seen here belongs to nobody and is dropped.
                mem_req_valid_c = 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    rsp_valid_c[owner_q] = 1'b1;
                    rsp_rdata_c = wen_q ? '0 : mem_rsp_rdata;
                    state_d     = IDLE;
                end
            end
            ERR_RSP: begin
                rsp_valid_c[owner_q] = 1'b1;
                rsp_err_c            = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            mask_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
        end
    end

    // Combinational outputs are forced low while reset is held so nothing leaks during the async window.
    assign req_ready     = rst ? 2'b00 : req_ready_c;
    assign rsp_valid     = rst ? 2'b00 : rsp_valid_c;
    assign rsp_rdata     = rst ? '0    : rsp_rdata_c;
    assign rsp_err       = rst ? 1'b0  : rsp_err_c;
    assign mem_req_valid = rst ? 1'b0  : mem_req_valid_c;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_mask      = mask_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table of single transactions plus hand-written sequences for
// arbitration ties, reset abort and a blocked second requester; responses checked from a scoreboard queue.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_wen;
    logic [63:0] req_wdata;
    logic [3:0]  req_mask;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_mask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wen       (req_wen),
        .req_wdata     (req_wdata),
        .req_mask      (req_mask),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_mask      (mem_mask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    typedef struct {
        bit          port;
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  mask;
        logic [31:0] wdata;
        logic [31:0] mrd;       // data the memory model returns
        int          dly;       // cycles mem_req_ready is held low
        int          lat;       // idle cycles in WAIT_RSP before the response
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   no_grant = 1'b0;

    function automatic vec_t mk(bit p, logic w, logic [31:0] a, logic [1:0] m, logic [31:0] wd,
                                logic [31:0] md, int d, int l, logic ee, logic [31:0] er);
        vec_t v;
        v.port = p; v.wen = w; v.addr = a; v.mask = m; v.wdata = wd;
        v.mrd = md; v.dly = d; v.lat = l; v.exp_err = ee; v.exp_rdata = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        exp_t e;
        @(negedge clk);
        if (rsp_valid !== 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", {30'b0, rsp_valid}, 32'h0);
            end else begin
                e = q.pop_front();
                chk("rsp_port",  {30'b0, rsp_valid}, 32'h1 << e.port);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err",   {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
        if (no_grant) chk("held_off", {30'b0, req_ready}, 32'h0);
    endtask

    task automatic drive_req(input vec_t v);
        req_valid[v.port]            = 1'b1;
        req_wen[v.port]              = v.wen;
        req_addr[v.port*32 +: 32]    = v.addr;
        req_wdata[v.port*32 +: 32]   = v.wdata;
        req_mask[v.port*2 +: 2]      = v.mask;
    endtask

    task automatic wait_grant(input vec_t v, input int maxc);
        exp_t e;
        bit   got = 1'b0;
        for (int n = 0; n < maxc && !got; n++) begin
            smp();
            if (req_ready !== 2'b00) begin
                got = 1'b1;
                chk("grant_port", {30'b0, req_ready}, 32'h1 << v.port);
                e.port = v.port; e.rdata = v.exp_rdata; e.err = v.exp_err;
                q.push_back(e);
            end
            adv();
        end
        chk("grant_seen", {31'b0, got}, 32'h1);
    endtask

    // Entered one cycle after the grant; leaves one cycle after the response.
    task automatic serve_mem(input vec_t v);
        if (v.exp_err) begin
            smp();
            chk("err_no_mem", {31'b0, mem_req_valid}, 32'h0);
            chk("err_rsp_cycle", q.size(), 32'h0);
            adv();
        end else begin
            for (int d = 0; d <= v.dly; d++) begin
                mem_req_ready = (d == v.dly);
                mem_rsp_valid = (d == v.dly);
                mem_rsp_rdata = 32'hBAD0BAD0;
                smp();
                chk("mem_req_valid", {31'b0, mem_req_valid}, 32'h1);
                chk("mem_addr",  mem_addr, v.addr);
                chk("mem_mask",  {30'b0, mem_mask}, {30'b0, v.mask});
                chk("mem_wen",   {31'b0, mem_wen}, {31'b0, v.wen});
                chk("mem_wdata", mem_wdata, v.wdata);
                chk("no_rsp_in_issue", {30'b0, rsp_valid}, 32'h0);
                adv();
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = 32'h0;
            for (int l = 0; l < v.lat; l++) begin
                smp();
                chk("early_rsp", {30'b0, rsp_valid}, 32'h0);
                adv();
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = v.mrd;
            smp();
            chk("rsp_cycle", q.size(), 32'h0);
            chk("no_b2b_grant", {30'b0, req_ready}, 32'h0);
            adv();
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = 32'h0;
        end
    endtask

    task automatic run_txn(input vec_t v);
        drive_req(v);
        wait_grant(v, 20);
        req_valid[v.port] = 1'b0;
        serve_mem(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        q.delete();
        adv();
        adv();
        rst = 1'b0;
    endtask

    vec_t tbl[9];
    vec_t tie_v[2];
    int   exp_tie[4];

    initial begin
        vec_t v, v0, v1;

        tbl[0] = mk(1'b0, 1'b0, 32'h100, 2'b10, 32'h0,        32'hDEADBEEF, 0, 0, 1'b0, 32'hDEADBEEF);
        tbl[1] = mk(1'b1, 1'b1, 32'h202, 2'b01, 32'h1234,     32'hFFFFFFFF, 3, 1, 1'b0, 32'h0);
        tbl[2] = mk(1'b0, 1'b0, 32'h101, 2'b10, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0);
        tbl[3] = mk(1'b0, 1'b0, 32'h100, 2'b11, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0);
        tbl[4] = mk(1'b1, 1'b0, 32'h003, 2'b00, 32'h0,        32'hA5,       1, 0, 1'b0, 32'hA5);
        tbl[5] = mk(1'b0, 1'b0, 32'h201, 2'b01, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0);
        tbl[6] = mk(1'b1, 1'b1, 32'h010, 2'b10, 32'hCAFEF00D, 32'h77,       0, 2, 1'b0, 32'h0);
        tbl[7] = mk(1'b0, 1'b0, 32'h006, 2'b01, 32'h0,        32'hBEEF,     0, 0, 1'b0, 32'hBEEF);
        tbl[8] = mk(1'b1, 1'b0, 32'h002, 2'b10, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0);

        tie_v[0] = mk(1'b0, 1'b0, 32'h040, 2'b10, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0);
        tie_v[1] = mk(1'b1, 1'b0, 32'h080, 2'b10, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0);
`ifdef DMEM_ARB_RR_EN
        exp_tie[0] = 0; exp_tie[1] = 1; exp_tie[2] = 0; exp_tie[3] = 1;
`else
        exp_tie[0] = 0; exp_tie[1] = 0; exp_tie[2] = 0; exp_tie[3] = 0;
`endif

        // Reset with both ports and the memory pushing: everything must stay quiet.
        rst = 1'b1;
        req_valid = 2'b11;
        req_wen = 2'b00;
        req_addr = {32'h80, 32'h40};
        req_wdata = 64'h0;
        req_mask = 4'b1010;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h12345678;
        smp();
        chk("rst_req_ready", {30'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i]);
            chk("scoreboard_drained", q.size(), 32'h0);
        end

        // Both ports valid continuously: grant order depends on the tie policy.
        do_reset();
        drive_req(tie_v[0]);
        drive_req(tie_v[1]);
        for (int i = 0; i < 4; i++) begin
            v = tie_v[exp_tie[i]];
            v.mrd = 32'h1000 + i;
            v.exp_rdata = 32'h1000 + i;
            wait_grant(v, 1);
            serve_mem(v);
        end
        req_valid = 2'b00;
        chk("tie_drained", q.size(), 32'h0);

        // Reset during WAIT_RSP, then a stale memory response arrives.
        do_reset();
        v = mk(1'b0, 1'b0, 32'h300, 2'b10, 32'h0, 32'h55, 0, 0, 1'b0, 32'h55);
        drive_req(v);
        wait_grant(v, 1);
        req_valid = 2'b00;
        mem_req_ready = 1'b1;
        smp();
        chk("pre_rst_mem_req", {31'b0, mem_req_valid}, 32'h1);
        adv();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        q.delete();
        smp();
        chk("abort_req_ready", {30'b0, req_ready}, 32'h0);
        chk("abort_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        chk("abort_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        adv();
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h55;
        smp();
        chk("late_rsp_dropped", {30'b0, rsp_valid}, 32'h0);
        adv();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        v = mk(1'b1, 1'b0, 32'h007, 2'b00, 32'h0, 32'h9A, 0, 0, 1'b0, 32'h9A);
        drive_req(v);
        wait_grant(v, 1);
        req_valid = 2'b00;
        serve_mem(v);
        chk("post_rst_drained", q.size(), 32'h0);

        // Port 1 arrives while port 0 is in flight; it is granted the cycle after port 0's response.
        v0 = mk(1'b0, 1'b0, 32'h020, 2'b10, 32'h0, 32'h11112222, 1, 1, 1'b0, 32'h11112222);
        v1 = mk(1'b1, 1'b0, 32'h009, 2'b00, 32'h0, 32'h3C,       0, 0, 1'b0, 32'h3C);
        drive_req(v0);
        wait_grant(v0, 1);
        req_valid[0] = 1'b0;
        drive_req(v1);
        no_grant = 1'b1;
        serve_mem(v0);
        no_grant = 1'b0;
        wait_grant(v1, 1);
        req_valid[1] = 1'b0;
        serve_mem(v1);
        chk("block_drained", q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port (addr/wen/wdata/mask/rdata) between two requesters: port 0 is the LSU stage and port 1 is a secondary master (debug/DMA loader). It sits between the LSU outputs and the memory model. It arbitrates, latches one request at a time, checks alignment against the 2-bit size mask, and routes the response back to the owner. Only one transaction is outstanding at any time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  2  per-port request valid; bit i = port i
req_ready  out  2  per-port accept pulse
req_addr  in  2*ADDR_W  per-port byte address; port i at [i*ADDR_W +: ADDR_W]
req_wen  in  2  per-port write enable
req_wdata  in  2*DATA_W  per-port write data
req_mask  in  4  per-port size: 00 byte, 01 half, 10 word, 11 illegal
rsp_valid  out  2  per-port response pulse
rsp_rdata  out  DATA_W  read data, shared by both ports and qualified by rsp_valid
rsp_err  out  1  misaligned/illegal flag, qualified by rsp_valid
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts the request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_W  latched write data
mem_mask  out  2  latched size
mem_rsp_valid  in  1  memory response; asserted for reads and write-acks
mem_rsp_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, ISSUE, WAIT_RSP, ERR_RSP. Registers: owner (1b), holding regs for addr/wen/wdata/mask, rr_last (1b).
- Reset (async, rst=1): state=IDLE, owner=0, rr_last=1 (so port 0 wins first), holding regs=0. All outputs are 0 in reset.
- IDLE: if any req_valid, pick a winner (see arbitration) and drive req_ready[winner]=1 for that cycle only. Latch the request and set owner=winner. If the latched request is legal, go to ISSUE; otherwise go to ERR_RSP. The loser's req_ready stays 0 and the loser must hold its request.
- Legality: mask 11 is illegal. mask 01 is illegal when addr[0]=1. mask 10 is illegal when addr[1:0]!=0. mask 00 is always legal.
- ISSUE: mem_req_valid=1 and mem_* come from the holding regs, stable until accepted. When mem_req_ready=1, go to WAIT_RSP. A mem_rsp_valid in the same cycle as acceptance is ignored; memory latency is at least 1 cycle.
- WAIT_RSP: on mem_rsp_valid, drive rsp_valid[owner]=1, rsp_rdata=mem_rsp_rdata (0 for writes), rsp_err=0. Both this pass-through and the return to IDLE happen in the same cycle.
- ERR_RSP: memory is never accessed. Drive rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0 for one cycle, then go to IDLE.
- Minimum legal latency: accept at cycle 0, mem_req_valid at cycle 1, response at cycle 2 or later. Illegal request: accept at cycle 0, error response at cycle 1.
- A new request is accepted only in IDLE. There is no back-to-back acceptance in the response cycle.
- rsp_valid and req_ready are one-hot or zero. They are never asserted in the same cycle.
- Arbitration: grant goes to the single valid port. If both ports are valid, the tie-break is set by the optional feature below. rr_last updates to the winner on every grant.
- req_valid dropping while not granted is allowed (no commitment). mem_rsp_valid outside WAIT_RSP is ignored.
- Asserting rst mid-transaction aborts it with no response. The memory side must also be reset.

Optional Feature:
DMEM_ARB_RR_EN.
- Defined: on a tie, the port != rr_last wins (round-robin), so neither port can starve the other.
- Undefined: port 0 (LSU) always wins ties (fixed priority). rr_last is still updated but unused.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT_RSP/ERR_RSP);
  - size constants MASK_B=2'b00, MASK_H=2'b01, MASK_W=2'b10;
  - function is_aligned(addr[1:0], mask).
- One sub-module, dmem_arb_pick: the combinational 2-way grant from req_valid and rr_last, containing the DMEM_ARB_RR_EN selection.

Test Plan:
- Port 0 read, word, addr 0x100; memory responds 2 cycles after accept with 0xDEADBEEF:
  - req_ready[0] at cycle 0; mem_req_valid with mem_addr=0x100, mem_mask=10 at cycle 1;
  - rsp_valid[0]=1, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Port 1 halfword write, addr 0x202, wdata 0x1234, mem_req_ready held low 3 cycles:
  - mem_* stay stable and are accepted on the 4th cycle;
  - write-ack gives rsp_valid[1]=1, rsp_rdata=0.
- Port 0 word read at addr 0x101:
  - req_ready[0] pulse, no mem_req_valid;
  - next cycle rsp_valid[0]=1, rsp_err=1. Repeat with mask=11 and expect the same result.
- Both ports valid continuously for 4 transactions:
  - with DMEM_ARB_RR_EN, grants are 0,1,0,1;
  - without it, grants are 0,0,0,0.
- rst asserted during WAIT_RSP, then a late mem_rsp_valid arrives:
  - all outputs go 0 immediately and state is IDLE;
  - no rsp_valid is produced.
- Port 1 requests while port 0's transaction is in WAIT_RSP:
  - req_ready[1] stays 0 until the cycle after rsp_valid[0], then is granted in IDLE.
